dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The module SHALL have parameter DM_ADDRESS, default 9, giving the byte-address width; storage depth is 2^(DM_ADDRESS-2) words.
REQ-002 The module SHALL have parameter DATA_W, default 32, giving the data width (4 byte lanes).
REQ-003 The module SHALL have parameter WAIT_CYCLES, default 2, legal range 0..15, giving the number of wait states per access.
REQ-004 The module SHALL use one clock and a synchronous, active-high reset, with ports as follows:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  requester presents a request.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_be  input  4  byte-lane enables; bit i selects bits [8i+7:8i].
- req_addr  input  DM_ADDRESS  byte address; bits [1:0] are ignored for indexing.
- req_wdata  input  DATA_W  write data, already lane-positioned.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  DATA_W  read word; 0 for write responses.
- rsp_err  output  1  illegal byte-enable pattern.

Function
REQ-005 The module SHALL implement an FSM with states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE, decoded from state.
REQ-006 On the edge where req_valid && req_ready, the module SHALL latch we, be, addr[DM_ADDRESS-1:2] and wdata.
- WAIT_CYCLES = 0: go to RESP.
- Otherwise: go to WAIT and load the counter with WAIT_CYCLES.
REQ-007 In WAIT, the counter SHALL decrement each cycle; on the edge where it reaches 0 the FSM SHALL go to RESP.
REQ-008 rsp_valid SHALL first be 1 exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-009 The memory access SHALL be performed on the edge entering RESP, and rsp_rdata/rsp_err SHALL be registered on that same edge.
REQ-010 Legal req_be values SHALL be 0001, 0010, 0100, 1000, 0011, 1100 and 1111; any other value SHALL set rsp_err=1.
REQ-011 When rsp_err=1, the module SHALL suppress the write and SHALL return rsp_rdata=0.
REQ-012 A legal write SHALL update only the enabled byte lanes of the word; other lanes SHALL be unchanged.
REQ-013 A legal read SHALL return the full stored word on rsp_rdata regardless of req_be (lane extraction and extension belong to the requester).
REQ-014 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL be held stable until rsp_ready=1; rsp_valid && rsp_ready SHALL move the FSM to IDLE.
REQ-015 After a response handshake, the next request SHALL NOT be accepted in the same cycle; req_ready SHALL rise in the following cycle.
REQ-016 req_valid while not in IDLE SHALL be ignored; input changes after the accept edge SHALL have no effect.
REQ-017 A read accepted after a write response to the same word SHALL return the written data.
REQ-018 The module SHALL NOT reset memory contents; words never written SHALL read X in simulation.

Reset
REQ-019 With reset=1 at a rising edge, the module SHALL set state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-020 Reset takes priority over a simultaneous request, which SHALL NOT be accepted.
REQ-021 Reset in WAIT SHALL drop the pending access and its write SHALL NOT occur; reset in RESP SHALL drop the response.
REQ-022 req_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-023 Bench SHALL cover the following directed scenarios, with WAIT_CYCLES=2 unless stated:
- Word write/read: write 0x0000_0010, be=1111, data 0xDEADBEEF, then read 0x010 -> rsp_valid on the 3rd cycle after each accept; read rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte write: on that word, write 0x012, be=0100, data 0x00AA0000, then read -> 0xDEAABEEF.
- Illegal enables: write with be=0101, data 0xFFFFFFFF -> rsp_err=1, rsp_rdata=0; a following read returns 0xDEAABEEF.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata and req_ready=0 stable; handshake on cycle 6; req_ready=1 next cycle.
- Reset in WAIT: write 0xCAFEF00D to 0x020, reset asserted one cycle after accept -> no rsp_valid; after an earlier write of 0x11111111 there, a read returns 0x11111111.
- WAIT_CYCLES=0 build: read -> rsp_valid in the cycle after accept; back-to-back requests with rsp_ready=1 are accepted every 2 cycles.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: single-port word memory behind a valid/ready request and
// response handshake. Each access takes WAIT_CYCLES wait states, then presents
// a held response. Byte-lane writes are supported. Illegal lane patterns are
// flagged and do not change the memory.
module dmem_responder #(
  parameter int DM_ADDRESS  = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [3:0]            req_be,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int IDX_W  = DM_ADDRESS - 2;
  localparam int DEPTH  = 1 << IDX_W;
  localparam int LANE_W = DATA_W / 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state;
  logic [3:0]        cnt;

  // Request fields captured at accept; later input changes must not matter.
  logic              lat_we;
  logic [3:0]        lat_be;
  logic [IDX_W-1:0]  lat_idx;
  logic [DATA_W-1:0] lat_wdata;

  logic [DATA_W-1:0] mem [DEPTH];

  // Fields of the access performed on the edge entering RESP.
  logic              acc_we;
  logic [3:0]        acc_be;
  logic [IDX_W-1:0]  acc_idx;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_legal;
  logic              accept;
  logic              enter_resp;

  // Byte-address bits [1:0] only select a lane inside the word.
  wire unused_addr_lsbs = &{1'b0, req_addr[1:0]};

  function automatic logic be_legal(input logic [3:0] be);
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
      default:                   be_legal = 1'b0;
    endcase
  endfunction

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign accept    = req_valid && req_ready;

  // With zero wait states RESP is entered on the accept edge itself, so the
  // access must use the live request; otherwise it uses the captured fields.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch
    // is inferred.
    acc_we    = lat_we;
    acc_be    = lat_be;
    acc_idx   = lat_idx;
    acc_wdata = lat_wdata;
    if (state == S_IDLE) begin
      acc_we    = req_we;
      acc_be    = req_be;
      acc_idx   = req_addr[DM_ADDRESS-1:2];
      acc_wdata = req_wdata;
    end
    acc_legal  = be_legal(acc_be);
    enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                 ((state == S_WAIT) && (cnt == 4'd1));
  end

  // Control FSM: IDLE -> (WAIT ->) RESP -> IDLE, with wait-state counter.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state <= S_RESP;
          end else begin
            state <= S_WAIT;
            cnt   <= 4'(WAIT_CYCLES);
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_RESP;
        end
        S_RESP: if (rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Capture request fields on the accept edge.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      lat_we    <= req_we;
      lat_be    <= req_be;
      lat_idx   <= req_addr[DM_ADDRESS-1:2];
      lat_wdata <= req_wdata;
    end
  end

  // Byte-lane write on the edge entering RESP; illegal patterns write nothing.
  always_ff @(posedge clk) begin
    // NOTE: memory contents are deliberately not reset; unwritten words read X.
    if (!reset && enter_resp && acc_we && acc_legal) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][i*LANE_W +: LANE_W] <= acc_wdata[i*LANE_W +: LANE_W];
      end
    end
  end

  // Response registers, loaded on the edge entering RESP and held until handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (enter_resp) begin
      rsp_err   <= !acc_legal;
      rsp_rdata <= (!acc_legal || acc_we) ? '0 : mem[acc_idx];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance (a_*) and a
// WAIT_CYCLES=0 instance (z_*) sharing clock and reset.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;

  logic        a_req_valid, a_req_ready, a_req_we;
  logic [3:0]  a_req_be;
  logic [8:0]  a_req_addr;
  logic [31:0] a_req_wdata;
  logic        a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_rsp_rdata;

  logic        z_req_valid, z_req_ready, z_req_we;
  logic [3:0]  z_req_be;
  logic [8:0]  z_req_addr;
  logic [31:0] z_req_wdata;
  logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_rsp_rdata;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_be(a_req_be), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_be(z_req_be), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete access on the WAIT_CYCLES=2 instance, response held for
  // 'stall' cycles with rsp_ready low before the handshake.
  task automatic do_access(input string tag, input logic we, input logic [3:0] be,
                           input logic [8:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           input int stall);
    check({tag, ":req_ready"}, 32'(a_req_ready), 32'd1);
    a_req_valid = 1'b1;
    a_req_we    = we;
    a_req_be    = be;
    a_req_addr  = addr;
    a_req_wdata = wdata;
    a_rsp_ready = 1'b0;
    tick();
    // Inputs change after accept and must have no effect.
    a_req_valid = 1'b0;
    a_req_we    = ~we;
    a_req_be    = 4'hF;
    a_req_addr  = ~addr;
    a_req_wdata = ~wdata;
    check({tag, ":c1_valid"}, 32'(a_rsp_valid), 32'd0);
    check({tag, ":c1_ready"}, 32'(a_req_ready), 32'd0);
    tick();
    check({tag, ":c2_valid"}, 32'(a_rsp_valid), 32'd0);
    tick();
    check({tag, ":c3_valid"}, 32'(a_rsp_valid), 32'd1);
    check({tag, ":rdata"}, a_rsp_rdata, exp_rdata);
    check({tag, ":err"}, 32'(a_rsp_err), 32'(exp_err));
    for (int i = 0; i < stall; i++) begin
      // A request while busy must be ignored.
      a_req_valid = 1'b1;
      a_req_we    = 1'b1;
      a_req_be    = 4'hF;
      a_req_addr  = addr;
      a_req_wdata = 32'h0BAD_0BAD;
      tick();
      check({tag, ":hold_valid"}, 32'(a_rsp_valid), 32'd1);
      check({tag, ":hold_rdata"}, a_rsp_rdata, exp_rdata);
      check({tag, ":hold_err"}, 32'(a_rsp_err), 32'(exp_err));
      check({tag, ":hold_ready"}, 32'(a_req_ready), 32'd0);
    end
    a_req_valid = 1'b0;
    a_rsp_ready = 1'b1;
    tick();
    a_rsp_ready = 1'b0;
    check({tag, ":post_valid"}, 32'(a_rsp_valid), 32'd0);
    check({tag, ":post_ready"}, 32'(a_req_ready), 32'd1);
  endtask

  initial begin
    reset       = 1'b1;
    a_req_valid = 1'b1;
    a_req_we    = 1'b1;
    a_req_be    = 4'hF;
    a_req_addr  = 9'h020;
    a_req_wdata = 32'hBAD0_BAD0;
    a_rsp_ready = 1'b0;
    z_req_valid = 1'b0;
    z_req_we    = 1'b0;
    z_req_be    = 4'hF;
    z_req_addr  = 9'h000;
    z_req_wdata = 32'h0;
    z_rsp_ready = 1'b1;

    // Reset with a simultaneous request pending.
    tick();
    tick();
    check("rst:rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("rst:rsp_rdata", a_rsp_rdata, 32'h0);
    check("rst:rsp_err", 32'(a_rsp_err), 32'd0);
    reset       = 1'b0;
    a_req_valid = 1'b0;
    check("rst:req_ready", 32'(a_req_ready), 32'd1);
    tick();
    check("rst:no_accept", 32'(a_rsp_valid), 32'd0);
    check("rst:still_idle", 32'(a_req_ready), 32'd1);

    // Seed word 0x020, then word write/read.
    do_access("seed20", 1'b1, 4'b1111, 9'h020, 32'h1111_1111, 32'h0, 1'b0, 0);
    do_access("wr10", 1'b1, 4'b1111, 9'h010, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
    do_access("rd10", 1'b0, 4'b1111, 9'h010, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);

    // Byte-lane write, then full-word read with a single-lane enable.
    do_access("wrb12", 1'b1, 4'b0100, 9'h012, 32'h00AA_0000, 32'h0, 1'b0, 0);
    do_access("rdb10", 1'b0, 4'b0001, 9'h010, 32'h0, 32'hDEAA_BEEF, 1'b0, 0);

    // Illegal enables: error, no write.
    do_access("wrill", 1'b1, 4'b0101, 9'h010, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
    do_access("rdill", 1'b0, 4'b1111, 9'h010, 32'h0, 32'hDEAA_BEEF, 1'b0, 0);

    // Backpressure: five stalled cycles, handshake on the sixth.
    do_access("bp", 1'b0, 4'b1111, 9'h010, 32'h0, 32'hDEAA_BEEF, 1'b0, 5);
    do_access("rdbp", 1'b0, 4'b1111, 9'h010, 32'h0, 32'hDEAA_BEEF, 1'b0, 0);

    // Reset one cycle after accept drops the pending write.
    a_req_valid = 1'b1;
    a_req_we    = 1'b1;
    a_req_be    = 4'hF;
    a_req_addr  = 9'h020;
    a_req_wdata = 32'hCAFE_F00D;
    tick();
    a_req_valid = 1'b0;
    reset       = 1'b1;
    tick();
    reset = 1'b0;
    check("rstw:ready", 32'(a_req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstw:no_valid", 32'(a_rsp_valid), 32'd0);
    end
    do_access("rd20", 1'b0, 4'b1111, 9'h020, 32'h0, 32'h1111_1111, 1'b0, 0);

    // Reset while in RESP drops the response.
    a_req_valid = 1'b1;
    a_req_we    = 1'b0;
    a_req_addr  = 9'h010;
    tick();
    a_req_valid = 1'b0;
    tick();
    tick();
    check("rstr:valid", 32'(a_rsp_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstr:dropped", 32'(a_rsp_valid), 32'd0);
    check("rstr:rdata", a_rsp_rdata, 32'h0);
    check("rstr:ready", 32'(a_req_ready), 32'd1);

    // Zero-wait instance: back-to-back requests with rsp_ready held high.
    check("z:ready0", 32'(z_req_ready), 32'd1);
    z_req_valid = 1'b1;
    z_req_we    = 1'b1;
    z_req_be    = 4'hF;
    z_req_addr  = 9'h004;
    z_req_wdata = 32'h1234_5678;
    tick();
    check("z:wr_valid", 32'(z_rsp_valid), 32'd1);
    check("z:wr_rdata", z_rsp_rdata, 32'h0);
    check("z:wr_ready", 32'(z_req_ready), 32'd0);
    z_req_we    = 1'b0;
    z_req_wdata = 32'h0;
    tick();
    check("z:gap_valid", 32'(z_rsp_valid), 32'd0);
    check("z:gap_ready", 32'(z_req_ready), 32'd1);
    tick();
    check("z:rd_valid", 32'(z_rsp_valid), 32'd1);
    check("z:rd_rdata", z_rsp_rdata, 32'h1234_5678);
    check("z:rd_err", 32'(z_rsp_err), 32'd0);
    z_req_valid = 1'b0;
    tick();
    check("z:end_valid", 32'(z_rsp_valid), 32'd0);
    check("z:end_ready", 32'(z_req_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
